// File: rtl/decode_pkg.sv
// RV32I decode types: operation classes, major opcodes and immediate formats.
package decode_pkg;
  typedef enum logic [3:0] {
    OP_NONE, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
    OP_IMM, OP, MISC_MEM, SYSTEM, OP_MULDIV
  } op_class_t;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;
endpackage

// File: rtl/pipeline_status.sv
// Shared pipeline handshake encodings: forward instruction status and backward flow control.
package pipeline_status;
  typedef enum logic [1:0] {VALID, BUBBLE, FETCH_FAULT, ILLEGAL_INSTRUCTION} forwards_t;
  typedef enum logic [1:0] {READY, STALL, JUMP} backwards_t;
endpackage

// File: rtl/decode_stage_if.sv
// Decode stage boundary: fetch-side inputs, execute-side outputs and the backward control relay.
interface decode_stage_if;
  import pipeline_status::*;
  import decode_pkg::*;

  logic [31:0] instruction_in;
  logic [31:0] program_counter_in;
  forwards_t   status_forwards_in;
  backwards_t  status_backwards_out;
  logic [31:0] jump_address_backwards_out;
  logic [31:0] instruction_reg_out;
  logic [31:0] program_counter_reg_out;
  logic [4:0]  rs1_address_reg_out;
  logic [4:0]  rs2_address_reg_out;
  logic [4:0]  rd_address_reg_out;
  logic [31:0] immediate_reg_out;
  op_class_t   op_class_reg_out;
  logic [2:0]  funct3_reg_out;
  logic        alt_funct_reg_out;
  forwards_t   status_forwards_out;
  backwards_t  status_backwards_in;
  logic [31:0] jump_address_backwards_in;

  modport master (
    input  instruction_in, program_counter_in, status_forwards_in,
           status_backwards_in, jump_address_backwards_in,
    output status_backwards_out, jump_address_backwards_out,
           instruction_reg_out, program_counter_reg_out,
           rs1_address_reg_out, rs2_address_reg_out, rd_address_reg_out,
           immediate_reg_out, op_class_reg_out, funct3_reg_out,
           alt_funct_reg_out, status_forwards_out
  );

  modport slave (
    output instruction_in, program_counter_in, status_forwards_in,
           status_backwards_in, jump_address_backwards_in,
    input  status_backwards_out, jump_address_backwards_out,
           instruction_reg_out, program_counter_reg_out,
           rs1_address_reg_out, rs2_address_reg_out, rd_address_reg_out,
           immediate_reg_out, op_class_reg_out, funct3_reg_out,
           alt_funct_reg_out, status_forwards_out
  );
endinterface

// File: rtl/decode_logic.sv
// Combinational RV32I field decode: register addresses, immediate, op class, illegal flag.
// Build option DECODE_STAGE_RVM_EN accepts the M-extension funct7 under OP.
module decode_logic
  import decode_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] immediate,
  output op_class_t   op_class,
  output logic        illegal
);
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  imm_fmt_t   fmt;
  logic       keep_rs1, keep_rs2, keep_rd;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  always_comb begin
    op_class = OP_NONE;
    fmt      = IMM_NONE;
    illegal  = 1'b0;
    keep_rs1 = 1'b1;
    keep_rs2 = 1'b0;
    keep_rd  = 1'b1;
    case (opcode)
      OPC_LUI:   begin op_class = LUI;   fmt = IMM_U; keep_rs1 = 1'b0; end
      OPC_AUIPC: begin op_class = AUIPC; fmt = IMM_U; keep_rs1 = 1'b0; end
      OPC_JAL:   begin op_class = JAL;   fmt = IMM_J; keep_rs1 = 1'b0; end
      OPC_JALR:  begin op_class = JALR;  fmt = IMM_I; illegal = (funct3 != 3'd0); end
      OPC_BRANCH: begin
        op_class = BRANCH; fmt = IMM_B; keep_rs2 = 1'b1; keep_rd = 1'b0;
        illegal  = (funct3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        op_class = LOAD; fmt = IMM_I;
        illegal  = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        op_class = STORE; fmt = IMM_S; keep_rs2 = 1'b1; keep_rd = 1'b0;
        illegal  = (funct3 > 3'd2);
      end
      OPC_OP_IMM: begin
        op_class = OP_IMM; fmt = IMM_I;
        if (funct3 == 3'd1)      illegal = (funct7 != 7'h00);
        else if (funct3 == 3'd5) illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
      end
      OPC_OP: begin
        op_class = OP; keep_rs2 = 1'b1;
        if (funct7 == 7'h01) begin
`ifdef DECODE_STAGE_RVM_EN
          op_class = OP_MULDIV;
`else
          illegal  = 1'b1;
`endif
        end else if (funct7 == 7'h20) begin
          illegal = (funct3 != 3'd0) && (funct3 != 3'd5);
        end else begin
          illegal = (funct7 != 7'h00);
        end
      end
      OPC_MISC_MEM: begin op_class = MISC_MEM; keep_rd = 1'b0; end
      OPC_SYSTEM:   begin op_class = SYSTEM; fmt = IMM_I; illegal = (funct3 == 3'd4); end
      default:      illegal = 1'b1;
    endcase
    // Compressed-space words and the erased-memory patterns never execute.
    if (instruction[1:0] != 2'b11 || instruction == 32'h0 || instruction == 32'hFFFF_FFFF)
      illegal = 1'b1;
  end

  always_comb begin
    case (fmt)
      IMM_I:   immediate = {{20{instruction[31]}}, instruction[31:20]};
      IMM_S:   immediate = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      IMM_B:   immediate = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
      IMM_U:   immediate = {instruction[31:12], 12'h000};
      IMM_J:   immediate = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
      default: immediate = 32'h0;
    endcase
  end

  assign rs1 = keep_rs1 ? instruction[19:15] : 5'd0;
  assign rs2 = keep_rs2 ? instruction[24:20] : 5'd0;
  assign rd  = keep_rd  ? instruction[11:7]  : 5'd0;
endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: one-cycle registered decode bundle, combinational backward relay.
// Build option DECODE_STAGE_RVM_EN enables M-extension decode to OP_MULDIV.
module decode_stage
  import pipeline_status::*;
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_INSTRUCTION = 32'h0000_0013,
  parameter logic [31:0] RESET_PC          = 32'h0000_0000
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.master bus
);
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic [31:0] dec_imm;
  op_class_t   dec_op_class;
  logic        dec_illegal;

  decode_logic u_decode_logic (
    .instruction (bus.instruction_in),
    .rs1         (dec_rs1),
    .rs2         (dec_rs2),
    .rd          (dec_rd),
    .immediate   (dec_imm),
    .op_class    (dec_op_class),
    .illegal     (dec_illegal)
  );

  assign bus.status_backwards_out       = bus.status_backwards_in;
  assign bus.jump_address_backwards_out = bus.jump_address_backwards_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.status_forwards_out     <= BUBBLE;
      bus.instruction_reg_out     <= RESET_INSTRUCTION;
      bus.program_counter_reg_out <= RESET_PC;
      bus.rs1_address_reg_out     <= 5'd0;
      bus.rs2_address_reg_out     <= 5'd0;
      bus.rd_address_reg_out      <= 5'd0;
      bus.immediate_reg_out       <= 32'h0;
      bus.op_class_reg_out        <= OP_NONE;
      bus.funct3_reg_out          <= 3'd0;
      bus.alt_funct_reg_out       <= 1'b0;
    end else if (bus.status_backwards_in == JUMP) begin
      // The word at the input is wrong-path; only the status needs killing.
      bus.status_forwards_out <= BUBBLE;
    end else if (bus.status_backwards_in != STALL) begin
      bus.instruction_reg_out     <= bus.instruction_in;
      bus.program_counter_reg_out <= bus.program_counter_in;
      bus.rs1_address_reg_out     <= 5'd0;
      bus.rs2_address_reg_out     <= 5'd0;
      bus.rd_address_reg_out      <= 5'd0;
      bus.immediate_reg_out       <= 32'h0;
      bus.op_class_reg_out        <= OP_NONE;
      bus.funct3_reg_out          <= 3'd0;
      bus.alt_funct_reg_out       <= 1'b0;
      case (bus.status_forwards_in)
        VALID: begin
          if (dec_illegal) begin
            bus.status_forwards_out <= ILLEGAL_INSTRUCTION;
          end else begin
            bus.status_forwards_out <= VALID;
            bus.rs1_address_reg_out <= dec_rs1;
            bus.rs2_address_reg_out <= dec_rs2;
            bus.rd_address_reg_out  <= dec_rd;
            bus.immediate_reg_out   <= dec_imm;
            bus.op_class_reg_out    <= dec_op_class;
            bus.funct3_reg_out      <= bus.instruction_in[14:12];
            bus.alt_funct_reg_out   <= bus.instruction_in[30];
          end
        end
        BUBBLE:      bus.status_forwards_out <= BUBBLE;
        FETCH_FAULT: bus.status_forwards_out <= FETCH_FAULT;
        default:     bus.status_forwards_out <= ILLEGAL_INSTRUCTION;
      endcase
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed plan items then random traffic against a reference model.
module tb_decode_stage;
  import pipeline_status::*;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if bus ();
  decode_stage dut (.clk(clk), .rst(rst), .bus(bus));

  // lvl: 0 = status only, 1 = status and decoded fields, 2 = also instruction and PC
  typedef struct {
    forwards_t   st;
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    op_class_t   op;
    logic [2:0]  f3;
    logic        alt;
    int          lvl;
    backwards_t  bwd;
    logic [31:0] jad;
  } rec_t;

  rec_t q[$];
  rec_t m;
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void clear_fields(inout rec_t r);
    r.imm = 32'h0; r.rs1 = 5'd0; r.rs2 = 5'd0; r.rd = 5'd0;
    r.op = OP_NONE; r.f3 = 3'd0; r.alt = 1'b0;
  endfunction

  // Reference decode, straight from the RV32I encoding rules.
  function automatic void ref_decode(input logic [31:0] w, inout rec_t r);
    int s, v;
    bit legal;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = w[14:12];
    f7 = w[31:25];
    s  = w[31] ? -1 : 0;
    legal = 1'b1;
    r.op = OP_NONE;
    v = 0;
    case (w[6:0])
      7'h03: begin r.op = LOAD;   legal = f3 inside {0, 1, 2, 4, 5}; v = s * 2048 + int'(w[30:20]); end
      7'h23: begin r.op = STORE;  legal = (f3 <= 2); v = s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]); end
      7'h63: begin
        r.op = BRANCH; legal = !(f3 inside {2, 3});
        v = s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      end
      7'h67: begin r.op = JALR;   legal = (f3 == 0); v = s * 2048 + int'(w[30:20]); end
      7'h6F: begin
        r.op = JAL;
        v = s * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      end
      7'h13: begin
        r.op = OP_IMM; v = s * 2048 + int'(w[30:20]);
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) legal = (f7 == 0) || (f7 == 7'h20);
      end
      7'h33: begin
        r.op = OP;
        legal = (f7 == 0) || (f7 == 7'h20 && f3 inside {0, 5});
`ifdef DECODE_STAGE_RVM_EN
        if (f7 == 7'h01) begin legal = 1'b1; r.op = OP_MULDIV; end
`endif
      end
      7'h37: begin r.op = LUI;   v = int'(w & 32'hFFFF_F000); end
      7'h17: begin r.op = AUIPC; v = int'(w & 32'hFFFF_F000); end
      7'h0F: r.op = MISC_MEM;
      7'h73: begin r.op = SYSTEM; legal = (f3 != 4); v = s * 2048 + int'(w[30:20]); end
      default: legal = 1'b0;
    endcase
    if (w == 32'h0 || w == 32'hFFFF_FFFF) legal = 1'b0;
    r.lvl = 2;
    if (!legal) begin
      r.st = ILLEGAL_INSTRUCTION;
      clear_fields(r);
    end else begin
      r.st  = VALID;
      r.imm = 32'(v);
      r.rs1 = (r.op inside {LUI, AUIPC, JAL}) ? 5'd0 : w[19:15];
      r.rs2 = (r.op inside {BRANCH, STORE, OP, OP_MULDIV}) ? w[24:20] : 5'd0;
      r.rd  = (r.op inside {BRANCH, STORE, MISC_MEM}) ? 5'd0 : w[11:7];
      r.f3  = f3;
      r.alt = w[30];
    end
  endfunction

  function automatic void model_reset(inout rec_t r);
    r.st = BUBBLE; r.ins = 32'h0000_0013; r.pc = 32'h0; r.lvl = 2;
    clear_fields(r);
  endfunction

  // Drives one cycle of inputs (called at posedge+1) and queues the expected response.
  task automatic drive(input logic [31:0] w, input logic [31:0] pc, input forwards_t f,
                       input backwards_t b, input logic [31:0] ja);
    rec_t r;
    bus.instruction_in            = w;
    bus.program_counter_in        = pc;
    bus.status_forwards_in        = f;
    bus.status_backwards_in       = b;
    bus.jump_address_backwards_in = ja;
    if (b == JUMP) begin
      m.st  = BUBBLE;
      m.lvl = 0;
    end else if (b == READY) begin
      m.ins = w;
      m.pc  = pc;
      case (f)
        VALID:       ref_decode(w, m);
        BUBBLE:      begin m.st = BUBBLE; m.lvl = 1; clear_fields(m); end
        FETCH_FAULT: begin m.st = FETCH_FAULT; m.lvl = 2; clear_fields(m); end
        default:     begin m.st = ILLEGAL_INSTRUCTION; m.lvl = 2; clear_fields(m); end
      endcase
    end
    r = m;
    r.bwd = b;
    r.jad = ja;
    q.push_back(r);
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input rec_t p, input string tag);
    chk({tag, "status_fwd"}, 32'(bus.status_forwards_out), 32'(p.st));
    if (p.lvl >= 1) begin
      chk({tag, "rs1"}, 32'(bus.rs1_address_reg_out), 32'(p.rs1));
      chk({tag, "rs2"}, 32'(bus.rs2_address_reg_out), 32'(p.rs2));
      chk({tag, "rd"}, 32'(bus.rd_address_reg_out), 32'(p.rd));
      chk({tag, "imm"}, bus.immediate_reg_out, p.imm);
      chk({tag, "op_class"}, 32'(bus.op_class_reg_out), 32'(p.op));
      chk({tag, "funct3"}, 32'(bus.funct3_reg_out), 32'(p.f3));
      chk({tag, "alt_funct"}, 32'(bus.alt_funct_reg_out), 32'(p.alt));
    end
    if (p.lvl >= 2) begin
      chk({tag, "instr"}, bus.instruction_reg_out, p.ins);
      chk({tag, "pc"}, bus.program_counter_reg_out, p.pc);
    end
  endtask

  // Monitor: a record's backward relay is checked mid-cycle, its registered result one cycle later.
  rec_t pend;
  bit   have_pend = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (have_pend) check_regs(pend, "");
      if (q.size() > 0) begin
        pend = q.pop_front();
        chk("status_bwd", 32'(bus.status_backwards_out), 32'(pend.bwd));
        chk("jump_addr", bus.jump_address_backwards_out, pend.jad);
        have_pend = 1'b1;
      end else begin
        have_pend = 1'b0;
      end
    end
  end

  localparam logic [6:0] OPCS [11] = '{7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h13,
                                       7'h33, 7'h37, 7'h17, 7'h0F, 7'h73};

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    k = $urandom_range(0, 13);
    w = $urandom;
    if (k < 11) begin
      w[6:0] = OPCS[k];
    end else if (k == 12) begin
      w[6:0] = 7'h33;
      case ($urandom_range(0, 2))
        0:       w[31:25] = 7'h00;
        1:       w[31:25] = 7'h01;
        default: w[31:25] = 7'h20;
      endcase
    end else if (k == 13) begin
      w = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
    end
    return w;
  endfunction

  initial begin
    rec_t rr;
    bus.instruction_in            = 32'h0;
    bus.program_counter_in        = 32'h0;
    bus.status_forwards_in        = BUBBLE;
    bus.status_backwards_in       = READY;
    bus.jump_address_backwards_in = 32'h0;
    model_reset(m);
    repeat (2) @(negedge clk);
    check_regs(m, "reset_");
    @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;

    drive(32'hFFF0_0093, 32'h10, VALID, READY, 32'h0);
    drive(32'hFE00_0EE3, 32'h14, VALID, READY, 32'h0);
    repeat (3) drive(32'h0000_0013, 32'h18, VALID, STALL, 32'h0);
    drive(32'h0000_0013, 32'h18, VALID, JUMP, 32'h100);
    drive(32'h0000_0000, 32'h20, VALID, READY, 32'h0);
    drive(32'h0000_3003, 32'h24, VALID, READY, 32'h0);
    drive(32'h1234_5678, 32'h44, FETCH_FAULT, READY, 32'h0);
    drive(32'h0220_8033, 32'h48, VALID, READY, 32'h0);
    drive(32'h0000_0013, 32'h4C, BUBBLE, READY, 32'h0);

    for (int i = 0; i < 400; i++) begin
      int rb, rf;
      forwards_t  f;
      backwards_t b;
      rb = $urandom_range(0, 9);
      rf = $urandom_range(0, 9);
      b = (rb < 7) ? READY : (rb < 9) ? STALL : JUMP;
      f = (rf < 8) ? VALID : (rf == 8) ? BUBBLE : FETCH_FAULT;
      drive(rand_instr(), $urandom & 32'hFFFF_FFFC, f, b, $urandom);
    end

    // Idle READY/BUBBLE cycles let the last records drain through the monitor.
    drive(32'h0, 32'h0, BUBBLE, READY, 32'h0);
    for (int t = 0; t < 20 && (q.size() > 0 || have_pend); t++) @(posedge clk);
    #1;
    checks++;
    if (q.size() > 0 || have_pend) begin
      errors++;
      $display("FAIL drain: %0d records left, expected 0", q.size());
    end
    mon_en = 1'b0;

    // Asynchronous reset while stalled on a legal instruction.
    drive(32'hFFF0_0093, 32'h80, VALID, READY, 32'h0);
    bus.status_backwards_in = STALL;
    #2 rst = 1'b0;
    #1;
    q.delete();
    model_reset(rr);
    check_regs(rr, "async_reset_");
    repeat (2) @(posedge clk);
    #1;
    check_regs(rr, "reset_hold_");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
